// File: rtl/snake_head_ctrl.sv
// -----------------------------------------------------------------------------
// snake_head_ctrl
// Game-logic stage for the 4x4 snake game. Owns the head cell and the apple
// cell. It advances the head one cell per game step in the last commanded
// direction. It detects wall collisions and apple captures, and respawns the
// apple from a free-running 4-bit LFSR.
//
// Cell encoding: row = cell[3:2] (0 = top), col = cell[1:0] (0 = left).
//
// Parameters
//   STEP_CYCLES : clock cycles per head step (>= 2)
// Ports
//   clock                         in   system clock, rising-edge updates
//   reset                         in   synchronous, active-low reset
//   start                         in   starts a new game from IDLE or OVER
//   btn_up/down/left/right        in   level-sensitive direction requests
//   position[3:0]                 out  head cell
//   apple[3:0]                    out  apple cell
//   score[3:0]                    out  apples eaten, saturating at 15
//   ate                           out  one-cycle pulse on a capture edge
//   playing                       out  high while a game is running
//   game_over                     out  high after a wall collision
// -----------------------------------------------------------------------------
module snake_head_ctrl #(
   parameter int STEP_CYCLES = 25000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   output logic [3:0] position,
   output logic [3:0] apple,
   output logic [3:0] score,
   output logic       ate,
   output logic       playing,
   output logic       game_over
);

   localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [CW-1:0] TERM = CW'(STEP_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_OVER = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   state_t        r_state;
   dir_t          r_dir;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_lfsr;
   logic [3:0]    r_position;
   logic [3:0]    r_apple;
   logic [3:0]    r_score;
   logic          r_ate;
   logic          r_playing;
   logic          r_game_over;

   dir_t          w_next_dir;
   logic [1:0]    w_row;
   logic [1:0]    w_col;
   logic [1:0]    w_row_dec;
   logic [1:0]    w_row_inc;
   logic [1:0]    w_col_dec;
   logic [1:0]    w_col_inc;
   logic          w_wall;
   logic [3:0]    w_new_cell;
   logic [3:0]    w_respawn;
   logic [3:0]    w_score_inc;
   logic [3:0]    w_lfsr_next;

   assign w_row     = r_position[3:2];
   assign w_col     = r_position[1:0];
   assign w_row_dec = w_row - 2'd1;
   assign w_row_inc = w_row + 2'd1;
   assign w_col_dec = w_col - 2'd1;
   assign w_col_inc = w_col + 2'd1;

   // x^4+x^3+1, shift left; the all-zero state is unreachable from 4'b0001
   assign w_lfsr_next = {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};

   // The apple must never respawn under the head, so bump it one cell on a clash
   assign w_respawn   = (r_lfsr == w_new_cell) ? (w_new_cell + 4'd1) : r_lfsr;
   assign w_score_inc = (r_score == 4'd15) ? 4'd15 : (r_score + 4'd1);

   // Direction priority: up > down > left > right > keep current
   always_comb begin
      w_next_dir = r_dir;
      if (btn_up) begin
         w_next_dir = DIR_UP;
      end else if (btn_down) begin
         w_next_dir = DIR_DOWN;
      end else if (btn_left) begin
         w_next_dir = DIR_LEFT;
      end else if (btn_right) begin
         w_next_dir = DIR_RIGHT;
      end else begin
         w_next_dir = r_dir;
      end
   end

   // Candidate head cell and wall check for a step in w_next_dir
   always_comb begin
      w_wall     = 1'b0;
      w_new_cell = r_position;
      case (w_next_dir)
         DIR_UP: begin
            w_wall     = (w_row == 2'd0);
            w_new_cell = {w_row_dec, w_col};
         end
         DIR_DOWN: begin
            w_wall     = (w_row == 2'd3);
            w_new_cell = {w_row_inc, w_col};
         end
         DIR_LEFT: begin
            w_wall     = (w_col == 2'd0);
            w_new_cell = {w_row, w_col_dec};
         end
         DIR_RIGHT: begin
            w_wall     = (w_col == 2'd3);
            w_new_cell = {w_row, w_col_inc};
         end
         default: begin
            w_wall     = 1'b0;
            w_new_cell = r_position;
         end
      endcase
   end

   // Game FSM with step counter, LFSR and all registered outputs
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_dir       <= DIR_RIGHT;
         r_cnt       <= '0;
         r_lfsr      <= 4'b0001;
         r_position  <= 4'd0;
         r_apple     <= 4'd15;
         r_score     <= 4'd0;
         r_ate       <= 1'b0;
         r_playing   <= 1'b0;
         r_game_over <= 1'b0;
      end else begin
         r_lfsr <= w_lfsr_next;
         r_ate  <= 1'b0;
         case (r_state)
            ST_IDLE, ST_OVER: begin
               r_cnt <= '0;
               if (start) begin
                  r_state     <= ST_PLAY;
                  r_dir       <= DIR_RIGHT;
                  r_position  <= 4'd0;
                  r_apple     <= 4'd15;
                  r_score     <= 4'd0;
                  r_playing   <= 1'b1;
                  r_game_over <= 1'b0;
               end else begin
                  r_state <= r_state;
               end
            end
            ST_PLAY: begin
               r_dir <= w_next_dir;
               if (r_cnt == TERM) begin
                  r_cnt <= '0;
                  if (w_wall) begin
                     // Position, apple and score freeze where they were
                     r_state     <= ST_OVER;
                     r_playing   <= 1'b0;
                     r_game_over <= 1'b1;
                  end else begin
                     r_position <= w_new_cell;
                     if (w_new_cell == r_apple) begin
                        r_score <= w_score_inc;
                        r_ate   <= 1'b1;
                        r_apple <= w_respawn;
                     end else begin
                        r_apple <= r_apple;
                     end
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_cnt       <= '0;
               r_playing   <= 1'b0;
               r_game_over <= 1'b0;
            end
         endcase
      end
   end

   assign position  = r_position;
   assign apple     = r_apple;
   assign score     = r_score;
   assign ate       = r_ate;
   assign playing   = r_playing;
   assign game_over = r_game_over;

endmodule

// File: tb/tb_snake_head_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snake_head_ctrl
// Self-checking bench for snake_head_ctrl with STEP_CYCLES = 4. A behavioural
// model (integer row/col, signed step vector, edges-since-start step timing)
// is compared against the DUT on every falling edge. Directed scenarios add
// hand-computed literal expectations, then a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_snake_head_ctrl;

   localparam int STEP = 4;

   logic       clock;
   logic       reset;
   logic       start;
   logic       btn_up;
   logic       btn_down;
   logic       btn_left;
   logic       btn_right;
   logic [3:0] position;
   logic [3:0] apple;
   logic [3:0] score;
   logic       ate;
   logic       playing;
   logic       game_over;

   int n_checks = 0;
   int n_errors = 0;
   bit check_en = 1'b0;

   // model state: mode 0 = idle, 1 = play, 2 = over
   int m_mode, m_row, m_col, m_apple, m_score, m_ate;
   int m_dr, m_dc, m_es, m_lfsr;
   int t_cur, t_nr, t_nc, t_cell;

   snake_head_ctrl #(.STEP_CYCLES(STEP)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .btn_left  (btn_left),
      .btn_right (btn_right),
      .position  (position),
      .apple     (apple),
      .score     (score),
      .ate       (ate),
      .playing   (playing),
      .game_over (game_over)
   );

   // 10 time-unit clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural reference: evaluated on every rising edge from the sampled inputs
   always @(posedge clock) begin
      if (!reset) begin
         m_mode = 0; m_row = 0; m_col = 0; m_apple = 15; m_score = 0; m_ate = 0;
         m_dr = 0; m_dc = 1; m_es = 0; m_lfsr = 1;
      end else begin
         t_cur  = m_lfsr;
         m_lfsr = ((m_lfsr * 2) % 16) + (((m_lfsr >> 3) ^ (m_lfsr >> 2)) & 1);
         m_ate  = 0;
         if (m_mode != 1) begin
            if (start) begin
               m_mode = 1; m_row = 0; m_col = 0; m_apple = 15; m_score = 0;
               m_dr = 0; m_dc = 1; m_es = 0;
            end
         end else begin
            if (btn_up)         begin m_dr = -1; m_dc = 0;  end
            else if (btn_down)  begin m_dr = 1;  m_dc = 0;  end
            else if (btn_left)  begin m_dr = 0;  m_dc = -1; end
            else if (btn_right) begin m_dr = 0;  m_dc = 1;  end
            m_es++;
            if (m_es % STEP == 0) begin
               t_nr = m_row + m_dr;
               t_nc = m_col + m_dc;
               if (t_nr < 0 || t_nr > 3 || t_nc < 0 || t_nc > 3) begin
                  m_mode = 2;
               end else begin
                  m_row  = t_nr;
                  m_col  = t_nc;
                  t_cell = t_nr * 4 + t_nc;
                  if (t_cell == m_apple) begin
                     if (m_score < 15) m_score++;
                     m_ate   = 1;
                     m_apple = (t_cur == t_cell) ? (t_cell + 1) % 16 : t_cur;
                  end
               end
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model
   always @(negedge clock) begin
      if (check_en) begin
         check("cmp_position",  position,  m_row * 4 + m_col);
         check("cmp_apple",     apple,     m_apple);
         check("cmp_score",     score,     m_score);
         check("cmp_ate",       ate,       m_ate);
         check("cmp_playing",   playing,   (m_mode == 1) ? 1 : 0);
         check("cmp_game_over", game_over, (m_mode == 2) ? 1 : 0);
      end
   end

   task automatic wait_n(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Pulse start for one edge; returns on the falling edge just after E0
   task automatic do_start();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   // Down for three steps, one right press, then run right into the apple at 15
   task automatic run_to_capture(input string tag);
      do_start();
      btn_down = 1'b1;
      wait_n(4);  check({tag, "_pos4"},  position, 4);
      wait_n(4);  check({tag, "_pos8"},  position, 8);
      wait_n(4);  check({tag, "_pos12"}, position, 12);
      btn_down  = 1'b0;
      btn_right = 1'b1;
      wait_n(1);
      btn_right = 1'b0;
      wait_n(3);  check({tag, "_pos13"}, position, 13);
      wait_n(4);  check({tag, "_pos14"}, position, 14);
      wait_n(4);  check({tag, "_pos15"}, position, 15);
      check({tag, "_score1"}, score, 1);
      check({tag, "_ate_hi"}, ate, 1);
      check({tag, "_apple_not15"}, {31'd0, apple != 4'd15}, 1);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0;
      btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;

      // 1: reset for two edges
      wait_n(2);
      check_en = 1'b1;
      reset = 1'b1;
      check("rst_position", position, 0);
      check("rst_apple", apple, 15);
      check("rst_score", score, 0);
      check("rst_ate", ate, 0);
      check("rst_playing", playing, 0);
      check("rst_game_over", game_over, 0);
      wait_n(3);

      // 2: straight right into the wall
      do_start();
      check("s2_playing", playing, 1);
      wait_n(4);  check("s2_pos1", position, 1);
      wait_n(4);  check("s2_pos2", position, 2);
      wait_n(4);  check("s2_pos3", position, 3);
      wait_n(4);
      check("s2_game_over", game_over, 1);
      check("s2_playing_lo", playing, 0);
      check("s2_pos_hold", position, 3);
      wait_n(2);

      // 3: down x3, right x3 onto the apple
      run_to_capture("s3");
      wait_n(1);  check("s3_ate_lo", ate, 0);
      wait_n(3);  check("s3_over", game_over, 1);
      wait_n(2);

      // 4: up from the top row collides on the first step
      do_start();
      btn_up = 1'b1;
      wait_n(4);
      check("s4_pos0", position, 0);
      check("s4_over", game_over, 1);
      btn_up = 1'b0;
      wait_n(2);

      // 5: left+down together at terminal count from cell 5
      do_start();
      btn_down = 1'b1;
      wait_n(4);  check("s5_pos4", position, 4);
      btn_down  = 1'b0;
      btn_right = 1'b1;
      wait_n(1);
      btn_right = 1'b0;
      wait_n(3);  check("s5_pos5", position, 5);
      wait_n(3);
      btn_left = 1'b1;
      btn_down = 1'b1;
      wait_n(1);  check("s5_pos9", position, 9);
      btn_left = 1'b0;
      btn_down = 1'b0;
      wait_n(8);  check("s5_over", game_over, 1);
      wait_n(2);

      // 6: capture, climb to cell 6, then reset mid-step
      run_to_capture("s6");
      btn_up = 1'b1;
      wait_n(4);  check("s6_pos11", position, 11);
      wait_n(4);  check("s6_pos7", position, 7);
      btn_up   = 1'b0;
      btn_left = 1'b1;
      wait_n(1);
      btn_left = 1'b0;
      wait_n(3);  check("s6_pos6", position, 6);
      wait_n(1);
      reset = 1'b0;
      wait_n(1);
      check("s6_rst_position", position, 0);
      check("s6_rst_apple", apple, 15);
      check("s6_rst_score", score, 0);
      check("s6_rst_ate", ate, 0);
      check("s6_rst_playing", playing, 0);
      reset = 1'b1;
      wait_n(2);
      do_start();
      wait_n(16); check("s6_over", game_over, 1);
      wait_n(1);
      do_start();
      check("s6_restart_playing", playing, 1);
      check("s6_restart_over", game_over, 0);
      check("s6_restart_pos", position, 0);
      check("s6_restart_score", score, 0);

      // randomized phase, checked by the every-cycle compare
      for (int i = 0; i < 3000; i++) begin
         btn_up    = ($urandom_range(0, 11) == 0);
         btn_down  = ($urandom_range(0, 11) == 0);
         btn_left  = ($urandom_range(0, 11) == 0);
         btn_right = ($urandom_range(0, 11) == 0);
         start     = ($urandom_range(0, 39) == 0);
         reset     = ($urandom_range(0, 299) != 0);
         @(negedge clock);
      end
      reset = 1'b1; start = 1'b0;
      btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
      wait_n(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
